// File: rtl/serial_pattern_tx_if.sv
// Request/status bundle between a pattern requester and serial_pattern_tx.
// The rpt signal exists only when SEQ_TX_REPEAT_EN is defined.
interface serial_pattern_tx_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] pattern;
`ifdef SEQ_TX_REPEAT_EN
  logic             rpt;
`endif
  logic             out;
  logic             busy;
  logic             done;
  logic [7:0]       edge_cnt;

`ifdef SEQ_TX_REPEAT_EN
  modport master (output start, pattern, rpt, input out, busy, done, edge_cnt);
  modport slave  (input start, pattern, rpt, output out, busy, done, edge_cnt);
`else
  modport master (output start, pattern, input out, busy, done, edge_cnt);
  modport slave  (input start, pattern, output out, busy, done, edge_cnt);
`endif
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB first, then an idle gap.
// Optional continuous repeat (rpt) is enabled by defining SEQ_TX_REPEAT_EN.
module serial_pattern_tx #(
  parameter int   WIDTH      = 8,
  parameter int   GAP        = 2,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  serial_pattern_tx_if.slave tx
);
  localparam int BW = (WIDTH < 3) ? 1 : $clog2(WIDTH);
  localparam int GW = (GAP < 1) ? 1 : $clog2(GAP + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       edge_cnt_q, edge_cnt_d;
  logic             clr_cnt;
`ifdef SEQ_TX_REPEAT_EN
  logic [WIDTH-1:0] pat_q, pat_d;
`endif

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    out_d     = out_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    clr_cnt   = 1'b0;
`ifdef SEQ_TX_REPEAT_EN
    pat_d     = pat_q;
`endif
    case (state_q)
      S_IDLE: begin
        out_d = IDLE_LEVEL;
        if (tx.start) begin
          shreg_d   = tx.pattern;
`ifdef SEQ_TX_REPEAT_EN
          pat_d     = tx.pattern;
`endif
          bit_cnt_d = '0;
          busy_d    = 1'b1;
          clr_cnt   = 1'b1;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        out_d     = shreg_q[WIDTH-1];
        shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (bit_cnt_q == BW'(WIDTH - 1)) begin
          gap_cnt_d = '0;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        // GAP idle cycles, then one more edge that closes the frame
        out_d     = IDLE_LEVEL;
        gap_cnt_d = gap_cnt_q + GW'(1);
        if (gap_cnt_q == GW'(GAP)) begin
          done_d = 1'b1;
`ifdef SEQ_TX_REPEAT_EN
          if (tx.rpt) begin
            out_d     = pat_q[WIDTH-1];
            shreg_d   = {pat_q[WIDTH-2:0], 1'b0};
            bit_cnt_d = BW'(1);
            state_d   = S_SEND;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
`else
          busy_d  = 1'b0;
          state_d = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    edge_cnt_d = edge_cnt_q;
    if (clr_cnt) begin
      edge_cnt_d = '0;
    end else if (!out_q && out_d && (edge_cnt_q != 8'hFF)) begin
      edge_cnt_d = edge_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      out_q      <= IDLE_LEVEL;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      edge_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

  // Pattern storage carries data only and needs no reset.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
`ifdef SEQ_TX_REPEAT_EN
    pat_q   <= pat_d;
`endif
  end

  assign tx.out      = out_q;
  assign tx.busy     = busy_q;
  assign tx.done     = done_q;
  assign tx.edge_cnt = edge_cnt_q;
endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx: vector table, corner sequences, random vs reference.
module tb_serial_pattern_tx;
  localparam int W = 8;
  localparam int G = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_pattern_tx_if #(.WIDTH(W)) bus ();
  serial_pattern_tx_if #(.WIDTH(W)) bus0 ();

  serial_pattern_tx #(.WIDTH(W), .GAP(G), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .reset(reset), .tx(bus)
  );
  serial_pattern_tx #(.WIDTH(W), .GAP(0), .IDLE_LEVEL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .tx(bus0)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [W-1:0]   pat;
    logic [W+G-1:0] bits;
    int             edges;
  } vec_t;
  vec_t vecs[6];

  // Reference model: a queue of per-edge expectations built from the frame rules.
  typedef struct packed {
    logic o;
    logic b;
    logic d;
  } exp_t;
  exp_t mq[$];
  int   m_cnt;
  logic m_prev;

  task automatic model_edge(input logic st, input logic [W-1:0] pat, output exp_t e);
    if (mq.size() != 0) begin
      e = mq.pop_front();
    end else if (st) begin
      e = '{o: 1'b0, b: 1'b1, d: 1'b0};
      for (int k = W - 1; k >= 0; k--) mq.push_back('{o: pat[k], b: 1'b1, d: 1'b0});
      for (int k = 0; k < G; k++) mq.push_back('{o: 1'b0, b: 1'b1, d: 1'b0});
      mq.push_back('{o: 1'b0, b: 1'b0, d: 1'b1});
      m_cnt = 0;
    end else begin
      e = '{o: 1'b0, b: 1'b0, d: 1'b0};
    end
    if (!m_prev && e.o && m_cnt < 255) m_cnt++;
    m_prev = e.o;
  endtask

  initial begin
    int       ndone;
    int       nbusy;
    int       pos;
    logic     st;
    logic     exp_o;
    logic [W-1:0] rp;
    logic [W-1:0] pa;
    logic [W+G-1:0] ref_b2;
    exp_t     e;

    vecs[0] = '{pat: 8'b1011_0010, bits: 10'b1011001000, edges: 3};
    vecs[1] = '{pat: 8'hFF,        bits: 10'b1111111100, edges: 1};
    vecs[2] = '{pat: 8'h00,        bits: 10'b0000000000, edges: 0};
    vecs[3] = '{pat: 8'hAA,        bits: 10'b1010101000, edges: 4};
    vecs[4] = '{pat: 8'h01,        bits: 10'b0000000100, edges: 1};
    vecs[5] = '{pat: 8'h5C,        bits: 10'b0101110000, edges: 2};
    ref_b2  = 10'b1011001000;

    reset = 1'b1;
    bus.start = 1'b0;  bus.pattern = '0;
    bus0.start = 1'b0; bus0.pattern = '0;
`ifdef SEQ_TX_REPEAT_EN
    bus.rpt = 1'b0;
    bus0.rpt = 1'b0;
`endif

    // Reset held three cycles, then released idle
    for (int i = 0; i < 6; i++) begin
      if (i == 3) reset = 1'b0;
      tick();
      chk($sformatf("rst%0d_out", i), bus.out, 0);
      chk($sformatf("rst%0d_busy", i), bus.busy, 0);
      chk($sformatf("rst%0d_done", i), bus.done, 0);
      chk($sformatf("rst%0d_edge", i), bus.edge_cnt, 0);
    end

    // Table-driven single frames
    for (int i = 0; i < 6; i++) begin
      bus.start = 1'b1; bus.pattern = vecs[i].pat;
      tick();
      bus.start = 1'b0; bus.pattern = ~vecs[i].pat;
      chk($sformatf("v%0d_acc_busy", i), bus.busy, 1);
      chk($sformatf("v%0d_acc_out", i), bus.out, 0);
      for (int k = 0; k < W + G; k++) begin
        tick();
        chk($sformatf("v%0d_out%0d", i, k), bus.out, vecs[i].bits[W+G-1-k]);
        chk($sformatf("v%0d_busy%0d", i, k), bus.busy, 1);
        chk($sformatf("v%0d_done%0d", i, k), bus.done, 0);
      end
      tick();
      chk($sformatf("v%0d_end_done", i), bus.done, 1);
      chk($sformatf("v%0d_end_busy", i), bus.busy, 0);
      chk($sformatf("v%0d_end_out", i), bus.out, 0);
      chk($sformatf("v%0d_edge", i), bus.edge_cnt, vecs[i].edges);
      tick();
      chk($sformatf("v%0d_post_done", i), bus.done, 0);
      chk($sformatf("v%0d_edge_hold", i), bus.edge_cnt, vecs[i].edges);
    end

    // Start during a frame is ignored
    bus.start = 1'b1; bus.pattern = 8'hB2;
    tick();
    bus.start = 1'b0;
    ndone = 0;
    for (int ed = 1; ed <= 14; ed++) begin
      if (ed == 4) begin bus.start = 1'b1; bus.pattern = 8'hFF; end
      tick();
      bus.start = 1'b0; bus.pattern = 8'h00;
      if (ed <= W + G) chk($sformatf("ign_out%0d", ed), bus.out, ref_b2[W+G-ed]);
      if (bus.done) ndone++;
    end
    chk("ign_done_count", ndone, 1);
    chk("ign_edge", bus.edge_cnt, 3);
    chk("ign_busy", bus.busy, 0);

    // Reset in the middle of a frame abandons it
    bus.start = 1'b1; bus.pattern = 8'hFF;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    chk("midrst_pre_out", bus.out, 1);
    chk("midrst_pre_edge", bus.edge_cnt, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_out", bus.out, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_edge", bus.edge_cnt, 0);
    chk("midrst_done", bus.done, 0);
    ndone = 0; nbusy = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (bus.done) ndone++;
      if (bus.busy) nbusy++;
    end
    chk("midrst_no_done", ndone, 0);
    chk("midrst_no_busy", nbusy, 0);

    // GAP=0 instance, restarted each time done is seen
    bus0.start = 1'b1; bus0.pattern = 8'hFF;
    tick();
    bus0.start = 1'b0;
    for (int f = 0; f < 3; f++) begin
      chk($sformatf("g0_f%0d_acc_busy", f), bus0.busy, 1);
      for (int k = 0; k < W; k++) begin
        tick();
        chk($sformatf("g0_f%0d_out%0d", f, k), bus0.out, 1);
      end
      tick();
      chk($sformatf("g0_f%0d_gapout", f), bus0.out, 0);
      chk($sformatf("g0_f%0d_done", f), bus0.done, 1);
      chk($sformatf("g0_f%0d_edge", f), bus0.edge_cnt, 1);
      if (f < 2) bus0.start = bus0.done;
      tick();
      bus0.start = 1'b0;
      chk($sformatf("g0_f%0d_accout", f), bus0.out, 0);
    end
    chk("g0_idle_busy", bus0.busy, 0);

`ifdef SEQ_TX_REPEAT_EN
    // Continuous repeat: period W+G, done alongside each new first bit
    pa = 8'hAA;
    bus.rpt = 1'b1; bus.start = 1'b1; bus.pattern = pa;
    tick();
    bus.start = 1'b0;
    for (int ed = 1; ed <= 32; ed++) begin
      tick();
      if (ed == 21) bus.rpt = 1'b0;
      pos = (ed - 1) % (W + G);
      exp_o = (ed <= 30 && pos < W) ? pa[W-1-pos] : 1'b0;
      chk($sformatf("rpt_out%0d", ed), bus.out, exp_o);
      chk($sformatf("rpt_busy%0d", ed), bus.busy, (ed <= 30) ? 1 : 0);
      chk($sformatf("rpt_done%0d", ed), bus.done, (ed == 11 || ed == 21 || ed == 31) ? 1 : 0);
      if (ed == 20) chk("rpt_edge_two_frames", bus.edge_cnt, 8);
    end
`endif

    // Randomized traffic against the reference model
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mq.delete();
    m_cnt = 0;
    m_prev = 1'b0;
    for (int c = 0; c < 400; c++) begin
      st = ($urandom_range(0, 3) == 0);
      rp = W'($urandom);
      bus.start = st; bus.pattern = rp;
      tick();
      model_edge(st, rp, e);
      chk($sformatf("rnd%0d_out", c), bus.out, e.o);
      chk($sformatf("rnd%0d_busy", c), bus.busy, e.b);
      chk($sformatf("rnd%0d_done", c), bus.done, e.d);
      chk($sformatf("rnd%0d_edge", c), bus.edge_cnt, m_cnt);
    end
    bus.start = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
